simp_alu_pipe: RTL and testbench

Parametrised, pipelined successor to the team's single-function clocked arithmetic block. It takes two WIDTH-bit operands plus an opcode and a saturation flag. It returns a WIDTH-bit result and an overflow flag after a configurable number of register stages. Input and output use valid/ready handshakes with per-stage backpressure, so it can sit between streaming producers and consumers in the basic_logic demos.

---
 rtl/simp_alu_pkg.sv | 15 +
 rtl/simp_alu_stage.sv | 44 ++++
 rtl/simp_alu_pipe.sv | 128 ++++++++++++
 tb/tb_simp_alu_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simp_alu_pkg.sv
// Shared types and default parameters for the pipelined arithmetic block.
package simp_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MAX = 2'd3
  } op_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_LATENCY = 2;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/simp_alu_stage.sv
// One pipeline slot: loads whenever it is empty or its own content is leaving,
// so bubbles ahead of a stalled consumer are collapsed.
module simp_alu_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid_i,
  output logic         up_ready_o,
  input  logic [W-1:0] up_data_i,
  output logic         dn_valid_o,
  input  logic         dn_ready_i,
  output logic [W-1:0] dn_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  always_comb begin
    load    = !valid_q || dn_ready_i;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = up_valid_i;
      if (up_valid_i) data_d = up_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign up_ready_o = load;
  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;

endmodule

// File: rtl/simp_alu_pipe.sv
// Pipelined ADD/SUB/MUL/MAX with optional saturation, valid/ready on both sides,
// and a wrapping count of delivered results.
module simp_alu_pipe
  import simp_alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [1:0]       op_in,
  input  logic             sat_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c_out,
  output logic             ovf_out,
  output logic [CNT_W-1:0] res_cnt
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             ovf;
  } stage_t;

  // Returns {ovf, result}.
  function automatic logic [WIDTH:0] alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input logic [1:0] op, input logic sat);
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res;
    logic               ovf;
    sum  = {1'b0, a} + {1'b0, b};
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    res  = '0;
    ovf  = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        ovf = sum[WIDTH];
        res = (sat && ovf) ? '1 : sum[WIDTH-1:0];
      end
      OP_SUB: begin
        ovf = (a < b);
        res = (sat && ovf) ? '0 : a - b;
      end
      OP_MUL: begin
        ovf = |prod[2*WIDTH-1:WIDTH];
        res = (sat && ovf) ? '1 : prod[WIDTH-1:0];
      end
      OP_MAX: begin
        ovf = 1'b0;
        res = (a > b) ? a : b;
      end
      default: ;
    endcase
    return {ovf, res};
  endfunction

  stage_t in_beat, out_beat;

  always_comb begin
    in_beat       = '0;
    in_beat.valid = in_valid;
    {in_beat.ovf, in_beat.result} = alu(a_in, b_in, op_in, sat_in);
  end

  for (genvar k = 0; k < LATENCY; k++) begin : g_st
    logic           up_valid, up_ready, dn_ready, vld;
    logic [WIDTH:0] up_data, dat;

    if (k == 0) begin : g_head
      assign up_valid = in_beat.valid;
      assign up_data  = {in_beat.ovf, in_beat.result};
    end else begin : g_body
      assign up_valid = g_st[k-1].vld;
      assign up_data  = g_st[k-1].dat;
    end

    // Readiness ripples back combinationally from out_ready; there is no skid buffer.
    if (k == LATENCY - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_link
      assign dn_ready = g_st[k+1].up_ready;
    end

    simp_alu_stage #(.W(WIDTH + 1)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid_i (up_valid),
      .up_ready_o (up_ready),
      .up_data_i  (up_data),
      .dn_valid_o (vld),
      .dn_ready_i (dn_ready),
      .dn_data_o  (dat)
    );
  end

  always_comb begin
    out_beat       = '0;
    out_beat.valid = g_st[LATENCY-1].vld;
    {out_beat.ovf, out_beat.result} = g_st[LATENCY-1].dat;
  end

  assign in_ready  = rst | g_st[0].up_ready;
  assign out_valid = out_beat.valid;
  assign c_out     = out_beat.result;
  assign ovf_out   = out_beat.ovf;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign res_cnt = cnt_q;

endmodule

// File: tb/tb_simp_alu_pipe.sv
// Bench for simp_alu_pipe: directed vectors, backpressure, bubble, reset and
// counter-wrap scenarios plus a randomized stream against an arithmetic model.
module tb_simp_alu_pipe;

  localparam int WIDTH   = 8;
  localparam int LATENCY = 2;
  localparam int CNT_W   = 16;
  localparam int CNT_W2  = 2;
  localparam int MAXV    = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_in = '0, b_in = '0;
  logic [1:0]       op_in = '0;
  logic             sat_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] c_out;
  logic             ovf_out;
  logic [CNT_W-1:0] res_cnt;

  logic              in_ready2, out_valid2, ovf_out2;
  logic [WIDTH-1:0]  c_out2;
  logic [CNT_W2-1:0] res_cnt2;

  simp_alu_pipe #(.WIDTH(WIDTH), .LATENCY(LATENCY), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .op_in(op_in), .sat_in(sat_in),
    .out_valid(out_valid), .out_ready(out_ready), .c_out(c_out),
    .ovf_out(ovf_out), .res_cnt(res_cnt)
  );

  // Narrow-counter copy fed identically, used to observe res_cnt wrap.
  simp_alu_pipe #(.WIDTH(WIDTH), .LATENCY(LATENCY), .CNT_W(CNT_W2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a_in(a_in), .b_in(b_in), .op_in(op_in), .sat_in(sat_in),
    .out_valid(out_valid2), .out_ready(out_ready), .c_out(c_out2),
    .ovf_out(ovf_out2), .res_cnt(res_cnt2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_stall = -1;
  int exp_cnt = 0;
  logic [WIDTH:0] exp_q[$];
  int acc_q[$];
  logic stall_prev = 1'b0;
  logic [WIDTH-1:0] prev_c = '0;
  logic prev_ovf = 1'b0;
  logic acc_last = 1'b0;
  logic smp_ov = 1'b0;
  logic [WIDTH-1:0] smp_c = '0;
  logic smp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Specification-level arithmetic on plain integers; returns {ovf, result}.
  function automatic logic [WIDTH:0] model(input int a, input int b, input int op, input bit sat);
    int full, res;
    bit ovf;
    full = 0; res = 0; ovf = 0;
    case (op)
      0: begin full = a + b; ovf = full > MAXV; res = ovf ? (sat ? MAXV : full - (MAXV + 1)) : full; end
      1: begin ovf = a < b; res = ovf ? (sat ? 0 : a - b + MAXV + 1) : a - b; end
      2: begin full = a * b; ovf = full > MAXV; res = ovf ? (sat ? MAXV : full % (MAXV + 1)) : full; end
      default: begin ovf = 0; res = (a > b) ? a : b; end
    endcase
    return {ovf, res[WIDTH-1:0]};
  endfunction

  // One clock: sample at negedge, update scoreboard, return just after posedge.
  task automatic step();
    logic [WIDTH:0] e;
    int a;
    @(negedge clk);
    cyc++;
    smp_ov = out_valid; smp_c = c_out; smp_ovf = ovf_out;
    acc_last = 1'b0;
    if (rst) begin
      chk("in_ready_in_reset", 32'(in_ready), 32'd1);
      exp_q.delete(); acc_q.delete();
      exp_cnt = 0; stall_prev = 1'b0;
    end else begin
      chk("res_cnt", 32'(res_cnt), 32'(exp_cnt % (1 << CNT_W)));
      chk("res_cnt_narrow", 32'(res_cnt2), 32'(exp_cnt % (1 << CNT_W2)));
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_c", 32'(c_out), 32'(prev_c));
        chk("hold_ovf", 32'(ovf_out), 32'(prev_ovf));
      end
      chk("in_ready", 32'(in_ready), 32'((exp_q.size() < LATENCY) || out_ready));
      if (exp_q.size() == 0) chk("out_valid_when_empty", 32'(out_valid), 32'd0);
      else if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("result", 32'(c_out), 32'(e[WIDTH-1:0]));
        chk("ovf", 32'(ovf_out), 32'(e[WIDTH]));
        if (a > last_stall) chk("latency", 32'(cyc - a), 32'(LATENCY));
        exp_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(a_in), int'(b_in), int'(op_in), sat_in));
        acc_q.push_back(cyc);
        acc_last = 1'b1;
      end
      if (!out_ready) last_stall = cyc;
      stall_prev = out_valid && !out_ready;
      prev_c = c_out; prev_ovf = ovf_out;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int op, input bit sat);
    a_in = WIDTH'(a); b_in = WIDTH'(b); op_in = 2'(op); sat_in = sat;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc_last) break;
    end
    chk("accept_within_budget", 32'(acc_last), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  int da[8]   = '{200, 200, 5, 10, 10, 16, 15, 100};
  int db[8]   = '{100, 100, 7, 20, 20, 16, 17, 50};
  int dop[8]  = '{0, 0, 0, 1, 1, 2, 2, 3};
  bit dsat[8] = '{0, 1, 0, 1, 0, 0, 0, 0};
  int dc[8]   = '{44, 255, 12, 0, 246, 0, 255, 100};
  bit dovf[8] = '{1, 1, 0, 1, 1, 1, 0, 0};

  initial begin
    int base, got;
    bit seen;

    // Reset held three cycles.
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf_out), 32'd0);
    chk("rst_res_cnt", 32'(res_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, one at a time.
    for (int t = 0; t < 8; t++) begin
      send(da[t], db[t], dop[t], dsat[t]);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        step();
        seen = smp_ov;
      end
      chk("directed_seen", 32'(seen), 32'd1);
      chk("directed_c", 32'(smp_c), 32'(dc[t]));
      chk("directed_ovf", 32'(smp_ovf), 32'(dovf[t]));
    end
    drain();

    // Backpressure: consumer stalled from the start, four beats offered.
    base = exp_cnt;
    out_ready = 1'b0;
    got = 0;
    a_in = 8'd3; b_in = 8'd4; op_in = 2'd0; sat_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (acc_last) begin
        got++;
        a_in = a_in + 8'd9; b_in = b_in + 8'd5; op_in = op_in + 2'd1;
      end
    end
    chk("bp_accepted_while_full", 32'(got), 32'(LATENCY));
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && got < 4; i++) begin
      step();
      if (acc_last) begin
        got++;
        a_in = a_in + 8'd9; b_in = b_in + 8'd5; op_in = op_in + 2'd1;
      end
    end
    in_valid = 1'b0;
    drain();
    chk("bp_res_cnt", 32'(res_cnt), 32'((base + 4) % (1 << CNT_W)));

    // Bubble collapse under a stalled consumer.
    out_ready = 1'b0;
    send(1, 2, 0, 0);
    step(); step();
    send(7, 3, 1, 0);
    chk("bubble_in_ready", 32'(in_ready), 32'd0);
    chk("bubble_out_valid", 32'(out_valid), 32'd1);
    chk("bubble_occupancy", 32'(exp_q.size()), 32'(LATENCY));
    drain();

    // Randomized stream with random backpressure.
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || acc_last) begin
        in_valid = ($urandom_range(0, 9) < 7);
        a_in = WIDTH'($urandom_range(0, MAXV));
        b_in = WIDTH'($urandom_range(0, MAXV));
        op_in = 2'($urandom_range(0, 3));
        sat_in = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b1;
    a_in = 8'd50; b_in = 8'd60; op_in = 2'd0; sat_in = 1'b0; in_valid = 1'b1;
    step();
    a_in = 8'd9;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (smp_ov) seen = 1'b1;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);
    chk("midrst_res_cnt", 32'(res_cnt), 32'd0);
    chk("midrst_res_cnt_narrow", 32'(res_cnt2), 32'd0);

    // Five transfers: the 2-bit counter wraps to 1.
    for (int t = 0; t < 5; t++) send(t * 11, t + 1, t % 4, 0);
    drain();
    step();
    chk("wrap_res_cnt", 32'(res_cnt), 32'd5);
    chk("wrap_res_cnt_narrow", 32'(res_cnt2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
